// File: rtl/arvi_bus_pkg.sv
// rtl/arvi_bus_pkg.sv - shared bus responder types: FSM states and latched request
`ifndef XLEN
`define XLEN 32
`endif

package arvi_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } bus_state_t;

  typedef struct packed {
    logic              wr_en;
    logic [`XLEN-1:0]  addr;
    logic [`XLEN-1:0]  wr_data;
    logic [3:0]        byte_en;
  } bus_req_t;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/bram_be.sv
// rtl/bram_be.sv - single-port synchronous RAM, 4 byte-lane write enables, registered read
module bram_be #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter string       INIT_FILE = "",
  localparam int         ADDR_W    = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [MEM_WORDS];

  // rdata only moves on reads, so it holds the last read word across writes.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int k = 0; k < 4; k++) begin
          if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/bus_mem_responder.sv
// rtl/bus_mem_responder.sv - memory bus responder: RAM-backed, wait states, range error
`ifndef XLEN
`define XLEN 32
`endif

module bus_mem_responder
  import arvi_bus_pkg::*;
#(
  parameter int unsigned      MEM_WORDS   = 4096,
  parameter logic [`XLEN-1:0] BASE_ADDR   = '0,
  parameter int unsigned      WAIT_STATES = 1,
  parameter string            INIT_FILE   = ""
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_bus_en,
  input  logic             i_wr_en,
  input  logic [`XLEN-1:0] i_wr_data,
  input  logic [`XLEN-1:0] i_addr,
  input  logic [3:0]       i_byte_en,
  output logic             o_ack,
  output logic [`XLEN-1:0] o_rd_data,
  output logic             o_err
);

  localparam int                         XW     = `XLEN;
  localparam int                         ADDR_W = $clog2(MEM_WORDS);
  localparam logic [XW-1:0]              SPAN   = XW'(MEM_WORDS) << 2;
  localparam logic [WAIT_CNT_W-1:0]      WS_CNT = WAIT_CNT_W'(WAIT_STATES);

  if (WAIT_STATES > 15) begin : g_bad_ws
    $error("bus_mem_responder: WAIT_STATES must be 0..15");
  end
  if ((MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_words
    $error("bus_mem_responder: MEM_WORDS must be a power of two");
  end
  if (XW != 32) begin : g_bad_xlen
    $error("bus_mem_responder: only 32-bit XLEN is supported");
  end

  bus_state_t              state, next_state;
  logic [WAIT_CNT_W-1:0]   cnt;
  bus_req_t                req, acc;
  logic [XW-1:0]           offset;
  logic                    in_range;
  logic                    enter_resp;
  logic                    ram_en;
  logic                    rd_from_ram;
  logic [31:0]             ram_q;

  // With zero wait states RAM is accessed on the acceptance edge, before the
  // request is latched, so the live bus fields feed the access in IDLE.
  always_comb begin
    acc = req;
    if (state == IDLE) begin
      acc.wr_en   = i_wr_en;
      acc.addr    = i_addr;
      acc.wr_data = i_wr_data;
      acc.byte_en = i_byte_en;
    end
  end

  // Unsigned wrap makes addresses below BASE_ADDR land far above SPAN.
  assign offset   = acc.addr - BASE_ADDR;
  assign in_range = (offset < SPAN);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_bus_en) next_state = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == WAIT_CNT_W'(1)) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign enter_resp = (next_state == RESP);
  assign ram_en     = enter_resp && in_range && !i_rst;

  bram_be #(
    .MEM_WORDS (MEM_WORDS),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (i_clk),
    .en    (ram_en),
    .we    (acc.wr_en),
    .be    (acc.byte_en),
    .addr  (offset[ADDR_W+1:2]),
    .wdata (acc.wr_data),
    .rdata (ram_q)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      req         <= '0;
      o_ack       <= 1'b0;
      o_err       <= 1'b0;
      rd_from_ram <= 1'b0;
    end else begin
      state <= next_state;
      o_ack <= enter_resp;
      o_err <= enter_resp && !in_range;
      if (state == IDLE && i_bus_en) begin
        req <= acc;
        cnt <= WS_CNT;
      end else if (state == WAIT) begin
        cnt <= cnt - 1'b1;
      end
      // Out-of-range reads present zero; writes keep the previous read word.
      if (enter_resp && !acc.wr_en) rd_from_ram <= in_range;
    end
  end

  assign o_rd_data = rd_from_ram ? ram_q : '0;

endmodule
